// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst sequencer: FSM encoding, transfer
// direction codes and the slave address width.
package i2c_pkg;

  localparam int SLAVE_ADDR_W = 7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_SETUP     = 4'd1;
  localparam logic [3:0] ST_PREFETCH  = 4'd2;
  localparam logic [3:0] ST_GO        = 4'd3;
  localparam logic [3:0] ST_WAIT_SLOT = 4'd4;
  localparam logic [3:0] ST_WAIT_END  = 4'd5;
  localparam logic [3:0] ST_NEXT      = 4'd6;
  localparam logic [3:0] ST_ABORT     = 4'd7;
  localparam logic [3:0] ST_FINISH    = 4'd8;

endpackage

// File: rtl/i2c_burst_addr_gen.sv
// Burst address generator: RAM/register address = base + idx wrapping at
// ADDR_W bits, effective burst length (0 or oversize means DEPTH) and the
// last-byte flag.
module i2c_burst_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] idx,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   len_eff,
  output logic              last
);

  localparam int DEPTH = 2**ADDR_W;

  // Wrap comes for free from the ADDR_W-bit sum; length is clamped to 1..DEPTH.
  always_comb begin
    addr    = base + idx;
    len_eff = len;
    if (len == '0 || len > (ADDR_W+1)'(DEPTH))
      len_eff = (ADDR_W+1)'(DEPTH);
    last    = ({1'b0, idx} == (len_eff - (ADDR_W+1)'(1)));
  end

endmodule

// File: rtl/i2c_burst_sequencer.sv
// Burst sequencer between the config logic and the byte-level I2C master:
// moves a block of bytes RAM -> slave (write) or slave -> RAM (read), with
// retry on NACK, continuous mode and abort on a direction change.
module i2c_burst_sequencer
  import i2c_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int MAX_RETRY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_rw,
  input  logic [SLAVE_ADDR_W-1:0] cfg_slave_addr,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [ADDR_W:0]         cfg_len,
  input  logic                    cfg_continuous,
  input  logic                    start,
  input  logic                    master_done,
  input  logic                    master_ready,
  input  logic                    master_ack,
  input  logic [7:0]              master_read_data,
  output logic                    master_go,
  output logic                    master_rw,
  output logic [ADDR_W:0]         master_num_bytes,
  output logic [SLAVE_ADDR_W-1:0] master_slave_addr,
  output logic [7:0]              master_reg_addr,
  output logic [7:0]              master_write_data,
  output logic                    master_stop,
  output logic [ADDR_W-1:0]       ram_radd,
  input  logic [7:0]              ram_rdout,
  output logic [ADDR_W-1:0]       ram_wadd,
  output logic [7:0]              ram_din,
  output logic                    ram_w,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [3:0]              retry_cnt
);

  logic [3:0]              state;
  logic [ADDR_W-1:0]       idx;
  logic                    sh_rw;
  logic [SLAVE_ADDR_W-1:0] sh_slave;
  logic [ADDR_W-1:0]       sh_base;
  logic [ADDR_W:0]         sh_len;
  logic                    sh_cont;
  logic                    rw_q;
  logic                    ready_q;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W:0]         len_eff;
  logic                    last;
  logic                    rw_toggle;
  logic                    ready_fall;
  logic                    arm;

  i2c_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .base    (sh_base),
    .idx     (idx),
    .len     (sh_len),
    .addr    (addr),
    .len_eff (len_eff),
    .last    (last)
  );

  assign ram_radd   = addr;
  assign ram_wadd   = addr;
  assign busy       = (state != ST_IDLE);
  assign rw_toggle  = cfg_rw ^ rw_q;
  assign ready_fall = ready_q & ~master_ready;
  // A burst (re)starts on start in IDLE, or on a direction change while busy
  // in continuous mode; both sample the live configuration.
  assign arm = enable & ((~busy & start) | (busy & rw_toggle & cfg_continuous));

  // Shadow configuration: captured only when a burst is armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_rw    <= RW_WRITE;
      sh_slave <= '0;
      sh_base  <= '0;
      sh_len   <= (ADDR_W+1)'(1);
      sh_cont  <= 1'b0;
    end else if (arm) begin
      sh_rw    <= cfg_rw;
      sh_slave <= cfg_slave_addr;
      sh_base  <= cfg_base;
      sh_len   <= cfg_len;
      sh_cont  <= cfg_continuous;
    end
  end

  // Input history for edge detection; held while frozen so no edge is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= 1'b0;
      ready_q <= 1'b0;
    end else if (enable) begin
      rw_q    <= cfg_rw;
      ready_q <= master_ready;
    end
  end

  // Main FSM; strobes are registered on entry to the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      retry_cnt         <= '0;
      error             <= 1'b0;
      master_go         <= 1'b0;
      master_stop       <= 1'b0;
      ram_w             <= 1'b0;
      done              <= 1'b0;
      master_rw         <= RW_WRITE;
      master_num_bytes  <= (ADDR_W+1)'(1);
      master_slave_addr <= '0;
      master_reg_addr   <= '0;
      master_write_data <= '0;
      ram_din           <= '0;
    end else begin
      master_go   <= 1'b0;
      master_stop <= 1'b0;
      ram_w       <= 1'b0;
      done        <= 1'b0;
      if (enable) begin
        if (busy && rw_toggle) begin
          // Direction change beats everything: abort the core, maybe re-arm.
          master_stop <= 1'b1;
          if (cfg_continuous) begin
            state     <= ST_SETUP;
            error     <= 1'b0;
            retry_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          case (state)
            ST_IDLE: begin
              if (start) begin
                state     <= ST_SETUP;
                error     <= 1'b0;
                retry_cnt <= '0;
              end
            end
            ST_SETUP: begin
              if (master_done) begin
                master_rw         <= sh_rw;
                master_num_bytes  <= len_eff;
                master_slave_addr <= sh_slave;
                master_reg_addr   <= 8'(sh_base);
                idx               <= '0;
                state             <= ST_PREFETCH;
              end
            end
            ST_PREFETCH: begin
              master_go <= 1'b1;
              state     <= ST_GO;
            end
            ST_GO: state <= ST_WAIT_SLOT;
            ST_WAIT_SLOT: begin
              if (master_ready) begin
                if (sh_rw == RW_WRITE) master_write_data <= ram_rdout;
                else                   ram_din           <= master_read_data;
                state <= ST_WAIT_END;
              end
            end
            ST_WAIT_END: begin
              if (ready_fall) begin
                if (sh_rw == RW_WRITE && !master_ack) begin
                  master_stop <= 1'b1;
                  state       <= ST_ABORT;
                end else begin
                  if (sh_rw == RW_READ) ram_w <= 1'b1;
                  if (last) begin
                    done  <= 1'b1;
                    state <= ST_FINISH;
                  end else begin
                    state <= ST_NEXT;
                  end
                end
              end
            end
            ST_NEXT: begin
              idx   <= idx + ADDR_W'(1);
              state <= ST_WAIT_SLOT;
            end
            ST_ABORT: begin
              if (retry_cnt < 4'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 4'd1;
                state     <= ST_SETUP;
              end else begin
                error <= 1'b1;
                state <= ST_IDLE;
              end
            end
            ST_FINISH: begin
              if (sh_cont) begin
                retry_cnt <= '0;
                state     <= ST_SETUP;
              end else begin
                state <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Directed bench for i2c_burst_sequencer: byte-level I2C core model, ROM-like
// RAM model, pulse monitor and one task per scenario.
module tb_i2c_burst_sequencer;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset, enable, cfg_rw, cfg_continuous, start;
  logic [6:0]        cfg_slave_addr;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W:0]   cfg_len;
  logic              master_done, master_ready, master_ack;
  logic [7:0]        master_read_data;
  logic              master_go, master_rw, master_stop;
  logic [ADDR_W:0]   master_num_bytes;
  logic [6:0]        master_slave_addr;
  logic [7:0]        master_reg_addr, master_write_data;
  logic [ADDR_W-1:0] ram_radd, ram_wadd;
  logic [7:0]        ram_rdout, ram_din;
  logic              ram_w, busy, done, error;
  logic [3:0]        retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  i2c_burst_sequencer #(.ADDR_W(ADDR_W), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_rw(cfg_rw),
    .cfg_slave_addr(cfg_slave_addr), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_continuous(cfg_continuous), .start(start),
    .master_done(master_done), .master_ready(master_ready),
    .master_ack(master_ack), .master_read_data(master_read_data),
    .master_go(master_go), .master_rw(master_rw),
    .master_num_bytes(master_num_bytes), .master_slave_addr(master_slave_addr),
    .master_reg_addr(master_reg_addr), .master_write_data(master_write_data),
    .master_stop(master_stop), .ram_radd(ram_radd), .ram_rdout(ram_rdout),
    .ram_wadd(ram_wadd), .ram_din(ram_din), .ram_w(ram_w),
    .busy(busy), .done(done), .error(error), .retry_cnt(retry_cnt)
  );

  // RAM contents are fixed: byte at address a is a*7+3.
  always @(posedge clk) ram_rdout <= 8'(ram_radd * 7 + 3);

  // Pulse counters and RAM write log.
  int go_cnt = 0, stop_cnt = 0, done_cnt = 0;
  logic [ADDR_W-1:0] waddr_q[$];
  logic [7:0]        wdat_q[$];
  always @(negedge clk) begin
    if (master_go === 1'b1)   go_cnt++;
    if (master_stop === 1'b1) stop_cnt++;
    if (done === 1'b1)        done_cnt++;
    if (ram_w === 1'b1) begin
      waddr_q.push_back(ram_wadd);
      wdat_q.push_back(ram_din);
    end
  end

  // I2C core model: 3 idle cycles, 3-cycle byte slot, ack after the slot.
  // Slave read data for byte b is 0x80+b. NACKs byte nack_byte while the
  // issued count is below nack_budget. master_stop aborts the burst.
  int nack_byte;
  int nack_budget;
  int nack_issued = 0;
  logic [7:0] wcap_q[$];

  task automatic core_tick(output bit stp);
    @(posedge clk); #1;
    stp = (master_stop === 1'b1);
  endtask

  initial begin : core_model
    bit stp;
    int n;
    bit rw;
    master_done = 1'b1; master_ready = 1'b0; master_ack = 1'b1; master_read_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (master_go === 1'b1) begin
        n = int'(master_num_bytes); rw = master_rw; master_done = 1'b0; stp = 1'b0;
        for (int b = 0; b < n && !stp; b++) begin
          for (int t = 0; t < 3 && !stp; t++) core_tick(stp);
          if (!stp) begin
            master_ready = 1'b1; master_read_data = 8'(8'h80 + b);
            for (int t = 0; t < 3 && !stp; t++) core_tick(stp);
            if (!stp) begin
              if (!rw) wcap_q.push_back(master_write_data);
              master_ready = 1'b0;
              if (b == nack_byte && nack_issued < nack_budget) begin
                master_ack = 1'b0; nack_issued++;
              end else master_ack = 1'b1;
            end
          end
        end
        for (int t = 0; t < 3 && !stp; t++) core_tick(stp);
        master_ready = 1'b0; master_ack = 1'b1; master_done = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_core(input int max);
    for (int i = 0; i < max; i++) begin
      if (master_done === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; start = 1'b0; cfg_rw = 1'b0; cfg_continuous = 1'b0;
    cfg_slave_addr = 7'h50; cfg_base = '0; cfg_len = 6'd4;
    nack_byte = -1; nack_budget = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({master_go, master_stop, ram_w, done, busy, error} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000", {master_go, master_stop, ram_w, done, busy, error});
    else n_pass++;
    n_checks++;
    if (retry_cnt !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else n_pass++;
    n_checks++;
    if (master_num_bytes !== 6'd1) $display("FAIL reset_num_bytes: got %0d want 1", master_num_bytes); else n_pass++;
    n_checks++;
    if ({master_rw, master_slave_addr, master_reg_addr, master_write_data, ram_din, ram_radd, ram_wadd} !== '0)
      $display("FAIL reset_addr_data: got %h want 0",
               {master_rw, master_slave_addr, master_reg_addr, master_write_data, ram_din, ram_radd, ram_wadd});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_freeze;
    int g0;
    g0 = go_cnt;
    enable = 1'b0;
    pulse_start;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL freeze_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (go_cnt - g0 !== 0) $display("FAIL freeze_go: got %0d want 0", go_cnt - g0); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_burst;
    int g0, d0, s0, cyc, nbad;
    bit ok;
    wait_core(200);
    cfg_rw = 1'b0; cfg_base = 5'd0; cfg_len = 6'd32; cfg_slave_addr = 7'h50;
    @(negedge clk);
    g0 = go_cnt; d0 = done_cnt; s0 = wcap_q.size();
    pulse_start;
    cyc = 1;
    while (master_go !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 3) $display("FAIL wr_start_to_go: got %0d cycles want 3", cyc); else n_pass++;
    n_checks++;
    if ({master_slave_addr, master_num_bytes, master_rw} !== {7'h50, 6'd32, 1'b0})
      $display("FAIL wr_core_cfg: got %h/%0d/%b want 50/32/0", master_slave_addr, master_num_bytes, master_rw);
    else n_pass++;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok) $display("FAIL wr_timeout: got busy want idle"); else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL wr_done: got %0d pulses want 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (go_cnt - g0 !== 1 || error !== 1'b0)
      $display("FAIL wr_go_err: got go=%0d err=%b want 1/0", go_cnt - g0, error);
    else n_pass++;
    n_checks++;
    if (wcap_q.size() - s0 !== 32) $display("FAIL wr_count: got %0d bytes want 32", wcap_q.size() - s0); else n_pass++;
    nbad = 0;
    for (int i = 0; i < 32 && s0 + i < wcap_q.size(); i++)
      if (wcap_q[s0 + i] !== 8'(i * 7 + 3)) nbad++;
    n_checks++;
    if (nbad !== 0) $display("FAIL wr_data: got %0d bad bytes want 0", nbad); else n_pass++;
  endtask

  task automatic test_read_wrap;
    int w0, d0;
    bit ok;
    logic [ADDR_W-1:0] ea;
    wait_core(200);
    cfg_rw = 1'b1; cfg_base = 5'd28; cfg_len = 6'd8;
    @(negedge clk);
    w0 = waddr_q.size(); d0 = done_cnt;
    pulse_start;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok) $display("FAIL rd_timeout: got busy want idle"); else n_pass++;
    n_checks++;
    if (waddr_q.size() - w0 !== 8) $display("FAIL rd_count: got %0d writes want 8", waddr_q.size() - w0); else n_pass++;
    for (int i = 0; i < 8 && w0 + i < waddr_q.size(); i++) begin
      ea = 5'(28 + i);
      n_checks++;
      if ({waddr_q[w0 + i], wdat_q[w0 + i]} !== {ea, 8'(8'h80 + i)})
        $display("FAIL rd_byte%0d: got addr %0d data %h want addr %0d data %h",
                 i, waddr_q[w0 + i], wdat_q[w0 + i], ea, 8'(8'h80 + i));
      else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL rd_done: got %0d pulses want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_nack_retry;
    int g0, st0, d0;
    bit ok;
    wait_core(200);
    cfg_rw = 1'b0; cfg_base = 5'd0; cfg_len = 6'd8;
    nack_byte = 2; nack_budget = nack_issued + 100;
    @(negedge clk);
    g0 = go_cnt; st0 = stop_cnt; d0 = done_cnt;
    pulse_start;
    wait_idle(3000, ok);
    nack_budget = nack_issued;
    n_checks++;
    if (!ok) $display("FAIL nack_timeout: got busy want idle"); else n_pass++;
    n_checks++;
    if (go_cnt - g0 !== 4) $display("FAIL nack_go: got %0d want 4", go_cnt - g0); else n_pass++;
    n_checks++;
    if (stop_cnt - st0 !== 4) $display("FAIL nack_stop: got %0d want 4", stop_cnt - st0); else n_pass++;
    n_checks++;
    if (retry_cnt !== 4'd3) $display("FAIL nack_retry_cnt: got %0d want 3", retry_cnt); else n_pass++;
    n_checks++;
    if (error !== 1'b1) $display("FAIL nack_error: got %b want 1", error); else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 0) $display("FAIL nack_done: got %0d want 0", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_nack_once;
    int g0, st0, d0, s0;
    bit ok;
    wait_core(200);
    nack_byte = 5; nack_budget = nack_issued + 1;
    @(negedge clk);
    g0 = go_cnt; st0 = stop_cnt; d0 = done_cnt; s0 = wcap_q.size();
    pulse_start;
    n_checks++;
    if ({error, retry_cnt} !== 5'b0) $display("FAIL once_clear: got err=%b retry=%0d want 0/0", error, retry_cnt); else n_pass++;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok) $display("FAIL once_timeout: got busy want idle"); else n_pass++;
    n_checks++;
    if (go_cnt - g0 !== 2 || stop_cnt - st0 !== 1)
      $display("FAIL once_go_stop: got %0d/%0d want 2/1", go_cnt - g0, stop_cnt - st0);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL once_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (retry_cnt !== 4'd1 || error !== 1'b0)
      $display("FAIL once_retry: got retry=%0d err=%b want 1/0", retry_cnt, error);
    else n_pass++;
    n_checks++;
    if (wcap_q.size() - s0 !== 14) $display("FAIL once_count: got %0d want 14", wcap_q.size() - s0);
    else n_pass++;
    if (wcap_q.size() - s0 == 14) begin
      n_checks++;
      if (wcap_q[s0 + 6] !== 8'd3 || wcap_q[s0 + 13] !== 8'd52)
        $display("FAIL once_restart_data: got %0d..%0d want 3..52", wcap_q[s0 + 6], wcap_q[s0 + 13]);
      else n_pass++;
    end
  endtask

  task automatic test_continuous;
    int d0, st0, c;
    bit ok, seen;
    wait_core(200);
    cfg_rw = 1'b0; cfg_base = 5'd3; cfg_len = 6'd4; cfg_continuous = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    pulse_start;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL cont_first_done: got none want pulse"); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (master_done === 1'b1) break;
      @(negedge clk);
    end
    c = 0;
    while (master_go !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    n_checks++;
    if (c < 1 || c > 3) $display("FAIL cont_rego: got %0d cycles want 1..3", c); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || busy !== 1'b1) $display("FAIL cont_second_done: got seen=%b busy=%b want 1/1", seen, busy); else n_pass++;
    cfg_continuous = 1'b0;
    @(negedge clk);
    st0 = stop_cnt;
    cfg_rw = 1'b1;
    wait_idle(20, ok);
    n_checks++;
    if (!ok || stop_cnt - st0 !== 1 || error !== 1'b0)
      $display("FAIL cont_exit: got idle=%b stops=%0d err=%b want 1/1/0", ok, stop_cnt - st0, error);
    else n_pass++;
  endtask

  task automatic test_rw_toggle;
    int w0, w1, st0;
    bit ok, seen;
    wait_core(200);
    cfg_rw = 1'b1; cfg_base = 5'd0; cfg_len = 6'd0; cfg_continuous = 1'b0;
    @(negedge clk);
    w0 = waddr_q.size();
    pulse_start;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (waddr_q.size() - w0 >= 10) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL tog_progress: got %0d writes want 10", waddr_q.size() - w0); else n_pass++;
    n_checks++;
    if (master_num_bytes !== 6'd32) $display("FAIL tog_len0: got %0d want 32", master_num_bytes); else n_pass++;
    st0 = stop_cnt;
    cfg_rw = 1'b0;
    wait_idle(20, ok);
    w1 = waddr_q.size();
    n_checks++;
    if (!ok) $display("FAIL tog_idle: got busy want idle"); else n_pass++;
    n_checks++;
    if (stop_cnt - st0 !== 1) $display("FAIL tog_stop: got %0d want 1", stop_cnt - st0); else n_pass++;
    repeat (60) @(negedge clk);
    n_checks++;
    if (waddr_q.size() !== w1 || busy !== 1'b0)
      $display("FAIL tog_after: got %0d extra writes busy=%b want 0/0", waddr_q.size() - w1, busy);
    else n_pass++;
    n_checks++;
    if (error !== 1'b0) $display("FAIL tog_error: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_reset_midburst;
    int st0;
    bit seen;
    wait_core(200);
    cfg_rw = 1'b0; cfg_base = 5'd5; cfg_len = 6'd8;
    @(negedge clk);
    pulse_start;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (master_ready === 1'b1) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    n_checks++;
    if (!seen || master_write_data !== 8'd38)
      $display("FAIL rst_pre: got ready=%b wdata=%0d want 1/38", seen, master_write_data);
    else n_pass++;
    st0 = stop_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({master_go, master_stop, ram_w, done, busy, error} !== 6'b0)
      $display("FAIL rst_strobes: got %b want 000000", {master_go, master_stop, ram_w, done, busy, error});
    else n_pass++;
    n_checks++;
    if ({master_write_data, ram_radd, master_num_bytes} !== {8'd0, 5'd0, 6'd1})
      $display("FAIL rst_outputs: got wdata=%0d radd=%0d nb=%0d want 0/0/1", master_write_data, ram_radd, master_num_bytes);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (stop_cnt - st0 !== 0) $display("FAIL rst_no_stop: got %0d want 0", stop_cnt - st0); else n_pass++;
    wait_core(500);
  endtask

  initial begin : main
    test_reset;
    test_enable_freeze;
    test_write_burst;
    test_read_wrap;
    test_nack_retry;
    test_nack_once;
    test_continuous;
    test_rw_toggle;
    test_reset_midburst;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_burst_sequencer.md
# i2c_burst_sequencer

Parametrised successor to the Spartan slave controller. It moves a configurable burst of bytes between a local dual-port RAM and an I2C slave through the byte-level I2C master core, in write (RAM → slave) or read (slave → RAM) mode. It adds a programmable base address and length with wrap-around, single-shot or continuous operation, NACK detection with bounded retry, and status outputs. It sits between the menu/config logic and the I2C master core.

## Interface
- `ADDR_W`, 5: RAM address width. `DEPTH = 2**ADDR_W`.
- `MAX_RETRY`, 3: number of retries after a NACK before error. Range 0–15.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, the FSM holds state and all strobes are 0.
- `cfg_rw` in 1: 0 = write to slave, 1 = read from slave. Any toggle aborts the burst.
- `cfg_slave_addr` in 7: 7-bit slave address.
- `cfg_base` in ADDR_W: first RAM address; also the first slave register address.
- `cfg_len` in ADDR_W+1: bytes per burst, 1..DEPTH. A value of 0 is treated as DEPTH.
- `cfg_continuous` in 1: 1 = restart a burst automatically after FINISH.
- `start` in 1: single-cycle pulse that launches a burst from IDLE.
- `master_done` in 1: the core is idle and can accept go.
- `master_ready` in 1: the core is in a byte slot.
- `master_ack` in 1: slave ACK (1 = ACK) for the last byte.
- `master_read_data` in 8: byte received from the slave.
- `master_go` out 1: one-cycle launch strobe.
- `master_rw` out 1: transfer direction to the core.
- `master_num_bytes` out ADDR_W+1: burst length to the core.
- `master_slave_addr` out 7: slave address to the core.
- `master_reg_addr` out 8: start register, zero-extended `cfg_base`.
- `master_write_data` out 8: byte to send.
- `master_stop` out 1: one-cycle abort strobe.
- `ram_radd` out ADDR_W: RAM read address.
- `ram_rdout` in 8: RAM read data, valid 1 cycle after `ram_radd`.
- `ram_wadd` out ADDR_W: RAM write address.
- `ram_din` out 8: RAM write data.
- `ram_w` out 1: RAM write enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a burst completes.
- `error` out 1: sticky; cleared by `start` or `reset`.
- `retry_cnt` out 4: number of retries used in the current burst.

## Operation
- States: IDLE, SETUP, PREFETCH, GO, WAIT_SLOT, WAIT_END, NEXT, ABORT, FINISH.
- **IDLE**: on `start`, latch all `cfg_*` into shadow registers, clear `error` and `retry_cnt`, then go to SETUP.
- **SETUP**: wait for `master_done`. Set `master_rw`, `master_num_bytes`, `master_slave_addr` and `master_reg_addr`. Set `idx=0`. Go to PREFETCH.
- **PREFETCH**: one cycle so that `ram_rdout` becomes valid. Then go to GO.
- **GO**: `master_go=1` for exactly one cycle. Then go to WAIT_SLOT.
- **WAIT_SLOT**: on `master_ready`, the action depends on mode:
  - Write: `master_write_data <= ram_rdout`.
  - Read: `ram_din <= master_read_data`.
  - Then go to WAIT_END.
- **WAIT_END**: on `master_ready` falling:
  - Write with `master_ack=0`: go to ABORT.
  - Read: `ram_w=1` for one cycle at `ram_wadd`.
  - Otherwise, if `idx==len-1` go to FINISH, else go to NEXT.
- **NEXT**: `idx++`, update the address, go to WAIT_SLOT.
- **ABORT**: `master_stop=1` for one cycle.
  - If `retry_cnt<MAX_RETRY`: increment `retry_cnt`, go to SETUP.
  - Otherwise: `error<=1`, go to IDLE.
- **FINISH**: `done=1` for one cycle.
  - If the shadow `continuous` is set: clear `retry_cnt`, go to SETUP.
  - Otherwise: go to IDLE.
- Addressing: `ram_radd = ram_wadd = (base + idx) mod DEPTH`, wrapping naturally at ADDR_W bits.
- `cfg_rw` toggle while busy (edge detected on a registered copy): `master_stop=1` for one cycle and go to IDLE. `error` is not set. This has priority over every other transition. If `cfg_continuous` is set, re-arm as if `start` were seen, using the new mode.
- `cfg_*` changes while busy have no effect other than `cfg_rw`; the shadow registers hold.
- `enable=0` freezes the state. `master_go`, `master_stop`, `ram_w` and `done` are forced to 0 while frozen.

## Timing
- Reset values:
  - State = IDLE.
  - `master_go`, `master_stop`, `ram_w`, `done`, `busy`, `error` = 0; `retry_cnt` = 0.
  - `master_rw` = 0; `master_num_bytes` = 1.
  - All address and data outputs = 0.
- `start` → `master_go` takes at least 3 cycles (IDLE→SETUP→PREFETCH→GO), provided `master_done` is already high.
- Every strobe is registered and exactly one cycle wide.
- `reset` mid-burst returns to IDLE on the next edge and issues no `master_stop`; the core has its own reset.
- Simultaneous `start` and `cfg_rw` toggle in IDLE: `start` wins, using the new `cfg_rw`.
- With `MAX_RETRY=0`, the first NACK sets `error`.

## Structure
- Shared package `i2c_pkg` holds:
  - the state encoding constants;
  - `RW_WRITE=0` and `RW_READ=1`;
  - the 7-bit slave address width.
- Natural sub-module: `i2c_burst_addr_gen`, which computes `base+idx` with wrap and the last-byte flag.
- The top level holds the FSM, shadow registers and retry logic.

## Test plan
- Write, base=0, len=32, ACK on every byte → RAM bytes 0..31 are presented on `master_write_data` in order; one `done`; `error=0`.
- Read, base=28, len=8 → `ram_w` asserts at addresses 28,29,30,31,0,1,2,3 with the slave data.
- NACK on byte 2 every attempt, MAX_RETRY=3 → 4 `master_go` pulses and 4 `master_stop` pulses; `retry_cnt=3`; `error=1`; no `done`.
- NACK once on byte 5, then ACK → one retry from base; `done` pulses; `retry_cnt=1`.
- `cfg_continuous=1`, len=4 → `done` is followed by a new `master_go` within 3 cycles of `master_done`.
- `cfg_rw` toggled at byte 10 → `master_stop` pulse, `ram_w` stays low afterward, state is IDLE.
- `reset` during WAIT_END → all outputs return to their reset values on the next cycle.
